// File: rtl/mem_access_unit_if.sv
// Request/response bundle between the execute stage and the load/store unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        busy;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault, busy
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault, busy
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: byte/half/word accesses onto a word-wide data memory,
// with alignment/range faults, load extension and read-modify-write stores.
module mem_access_unit #(
  parameter int unsigned DEPTH_WORDS = 32
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.slave   bus,
  output logic               mem_re,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        write_q;
  logic        unsigned_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  logic        accept;
  logic        req_fault;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept = bus.req_valid && (state == IDLE);

  // Fault check on the incoming request: reserved size, misalignment, range.
  always_comb begin
    req_fault = 1'b0;
    if (bus.req_size == 2'b11)                             req_fault = 1'b1;
    if (bus.req_size == 2'b01 && bus.req_addr[0])          req_fault = 1'b1;
    if (bus.req_size == 2'b10 && bus.req_addr[1:0] != '0)  req_fault = 1'b1;
    if ({2'b00, bus.req_addr[31:2]} >= DEPTH_WORDS)        req_fault = 1'b1;
  end

  // Lane extraction and sign/zero extension of the read word.
  always_comb begin
    byte_val = '0;
    case (addr_q[1:0])
      2'd0:    byte_val = mem_rdata[7:0];
      2'd1:    byte_val = mem_rdata[15:8];
      2'd2:    byte_val = mem_rdata[23:16];
      default: byte_val = mem_rdata[31:24];
    endcase
    half_val = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {24'd0, byte_val} : {{24{byte_val[7]}}, byte_val};
      2'b01:   load_ext = unsigned_q ? {16'd0, half_val} : {{16{half_val[15]}}, half_val};
      default: load_ext = mem_rdata;
    endcase
  end

  // Store merge: overwrite only the addressed lanes of the read word.
  always_comb begin
    merged = mem_rdata;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_next     = state;
    bus.req_ready  = (state == IDLE);
    bus.busy       = (state != IDLE);
    bus.resp_valid = (state == DONE);
    bus.resp_rdata = rdata_q;
    bus.resp_fault = fault_q;
    mem_re         = (state == READ) && !reset;
    mem_we         = (state == WRITE) && !reset;
    mem_addr       = '0;
    mem_wdata      = '0;
    if (mem_re || mem_we) mem_addr = {2'b00, addr_q[31:2]};
    if (mem_we)           mem_wdata = wdata_q;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_fault)                   state_next = DONE;
          else if (!bus.req_write)         state_next = READ;
          else if (bus.req_size == 2'b10)  state_next = WRITE;
          else                             state_next = READ;
        end
      end
      READ:    state_next = write_q ? WRITE : DONE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, load result capture and merged-word capture.
  // wdata_q holds the raw store data until READ replaces it with the merged word.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      size_q     <= '0;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q     <= bus.req_addr;
            size_q     <= bus.req_size;
            write_q    <= bus.req_write;
            unsigned_q <= bus.req_unsigned;
            wdata_q    <= bus.req_wdata;
            rdata_q    <= '0;
            fault_q    <= req_fault;
          end
        end
        READ: begin
          if (write_q) wdata_q <= merged;
          else         rdata_q <= load_ext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a word-array memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_access_unit_if bus ();

  mem_access_unit #(.DEPTH_WORDS(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];

  assign mem_rdata = (mem_addr < 32) ? mem[mem_addr[4:0]] : 32'd0;

  always @(posedge clk) if (mem_we && mem_addr < 32) mem[mem_addr[4:0]] <= mem_wdata;

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int unsigned lat;
    int unsigned re;
    int unsigned we;
    logic [31:0] idx;
    logic [31:0] wdata;
    int unsigned acc;
  } exp_t;

  exp_t sbq[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned re_cnt = 0;
  int unsigned we_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: tallies strobes per transaction and checks each response.
  always @(negedge clk) begin
    if (reset) begin
      re_cnt = 0;
      we_cnt = 0;
    end else begin
      if (mem_re) begin
        re_cnt++;
        if (sbq.size() > 0) chk("read_index", mem_addr, sbq[0].idx);
      end
      if (mem_we) begin
        we_cnt++;
        if (sbq.size() > 0) begin
          chk("write_index", mem_addr, sbq[0].idx);
          chk("write_word", mem_wdata, sbq[0].wdata);
        end
      end
      if (bus.resp_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_fault", {31'd0, bus.resp_fault}, {31'd0, e.fault});
          chk("latency", cycle - e.acc + 1, e.lat);
          chk("read_strobes", re_cnt, e.re);
          chk("write_strobes", we_cnt, e.we);
          chk("busy_in_done", {31'd0, bus.busy}, 32'd1);
        end
        re_cnt = 0;
        we_cnt = 0;
      end
    end
  end

  // Reference model: computes the outcome of one request from the access rules.
  function automatic exp_t model(input logic wr, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    logic [31:0] idx, old, v, nw;
    int unsigned sh;
    idx = addr / 4;
    e.idx = idx;
    e.rdata = 0;
    e.wdata = 0;
    e.fault = (sz == 3) || (sz == 1 && addr % 2 != 0) || (sz == 2 && addr % 4 != 0) || (idx >= 32);
    old = (idx < 32) ? ref_mem[idx[4:0]] : 32'd0;
    if (e.fault) begin
      e.lat = 1; e.re = 0; e.we = 0;
    end else if (!wr) begin
      e.lat = 2; e.re = 1; e.we = 0;
      if (sz == 0) begin
        sh = 8 * (addr % 4);
        v = (old >> sh) & 32'hFF;
        if (!uns && v >= 128) v = v | 32'hFFFFFF00;
      end else if (sz == 1) begin
        sh = 16 * ((addr / 2) % 2);
        v = (old >> sh) & 32'hFFFF;
        if (!uns && v >= 32768) v = v | 32'hFFFF0000;
      end else begin
        v = old;
      end
      e.rdata = v;
    end else begin
      if (sz == 2) begin
        e.lat = 2; e.re = 0; e.we = 1;
        nw = wd;
      end else begin
        e.lat = 3; e.re = 1; e.we = 1;
        if (sz == 0) begin
          sh = 8 * (addr % 4);
          nw = (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        end else begin
          sh = 16 * ((addr / 2) % 2);
          nw = (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        end
      end
      e.wdata = nw;
      ref_mem[idx[4:0]] = nw;
    end
    return e;
  endfunction

  // Driver: called at posedge+1; waits for acceptance, then queues the expectation.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input bit hold);
    int unsigned w;
    exp_t e;
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      bus.req_valid = 1'b0;
      return;
    end
    e = model(wr, sz, uns, addr, wd);
    e.acc = cycle + 1;
    sbq.push_back(e);
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned w;
    w = 0;
    while (sbq.size() > 0 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (sbq.size() > 0) begin
      chk("drain_timeout", sbq.size(), 32'd0);
      sbq.delete();
    end
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[3] = 32'h8899AABB;
    ref_mem[3] = 32'h8899AABB;

    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_fault", {31'd0, bus.resp_fault}, 32'd0);
    chk("rst_mem_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    do_req(1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, 1'b0);          // lb
    do_req(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, 1'b0);          // lbu
    do_req(1'b1, 2'b01, 1'b0, 32'h0E, 32'h00001234, 1'b0);   // sh
    do_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b0);          // lw
    do_req(1'b0, 2'b10, 1'b0, 32'h0E, 32'h0, 1'b0);          // misaligned lw
    do_req(1'b1, 2'b01, 1'b0, 32'h0D, 32'hFFFF, 1'b0);       // misaligned sh
    do_req(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1'b0);          // reserved size
    do_req(1'b1, 2'b10, 1'b0, 32'h80, 32'hDEADBEEF, 1'b0);   // out of range
    do_req(1'b1, 2'b10, 1'b0, 32'h7C, 32'hDEADBEEF, 1'b0);   // last word
    do_req(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 1'b0);
    drain();

    // Sub-word store aborted by reset during its READ cycle.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size = 2'b00;
    bus.req_addr = 32'h0C;
    bus.req_wdata = 32'h55;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("abort_in_read_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_strobes_in_reset", {30'd0, mem_re, mem_we}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b0);          // word 3 unchanged

    // Back-to-back loads with req_valid held.
    do_req(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b1);
    do_req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b0);
    drain();

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = $urandom_range(0, 'h9F);
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, bit'($urandom_range(0, 1)));
    end
    bus.req_valid = 1'b0;
    drain();
    repeat (2) @(posedge clk);

    for (int i = 0; i < 32; i++) chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit between the execute stage and the 32-word data memory. Takes one byte/halfword/word load or store per request, checks alignment and range, turns it into word-wide memory cycles, and returns sign- or zero-extended load data. Sub-word stores use read-modify-write. The unit holds `busy` while an access is in flight so the datapath can stall.

## Interface
- `DEPTH_WORDS`, 32: number of data-memory words; word index ≥ `DEPTH_WORDS` faults.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE. A request is accepted on an edge where `req_valid & req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved (faults).
- `req_unsigned` in 1: zero-extend loads when 1, sign-extend when 0.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, taken from the low bits.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data. 0 for stores and faults.
- `resp_fault` out 1: valid with `resp_valid`.
- `busy` out 1: high whenever state ≠ IDLE.
- `mem_re` out 1: memory read strobe.
- `mem_we` out 1: memory write strobe.
- `mem_addr` out 32: word index, `{2'b00, addr[31:2]}`. 0 when idle.
- `mem_wdata` out 32: full word to write. 0 unless `mem_we`.
- `mem_rdata` in 32: memory read data, combinational from `mem_addr`.

## Operation
- States: IDLE, READ, WRITE, DONE.
- On accept, latch addr, size, write, unsigned and wdata. Fault is evaluated at accept and is the OR of:
  - size = 11;
  - half with addr[0] ≠ 0;
  - word with addr[1:0] ≠ 0;
  - word index ≥ `DEPTH_WORDS`.
- Transitions out of IDLE on accept:
  - fault → DONE;
  - load → READ;
  - word store → WRITE;
  - byte/half store → READ.
- Transitions out of the other states:
  - READ, load: capture the extracted and extended `mem_rdata` → DONE.
  - READ, sub-word store: capture `mem_rdata`, build the merged word → WRITE.
  - WRITE → DONE.
  - DONE → IDLE.
- Lane mapping is little-endian.
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Half h = addr[1] occupies bits [16h+15:16h].
- Merge: replace only the addressed byte/half lanes with `req_wdata[7:0]` / `req_wdata[15:0]`. Other lanes keep the read value.
- Load extension:
  - byte: bit 7 replicated when signed, zeros when unsigned;
  - half: bit 15 replicated when signed, zeros when unsigned;
  - word: passed unchanged.
- Strobes are decoded from the state register and gated by `!reset`:
  - `mem_re = (state==READ) & !reset`;
  - `mem_we = (state==WRITE) & !reset`.
- A faulted request issues no memory strobe of any kind.
- `resp_valid = (state==DONE)`. `resp_rdata` and `resp_fault` are registered and held stable through DONE.
- New requests are ignored outside IDLE because `req_ready` is 0. Requesters must hold `req_valid` until accepted.

## Timing
- Reset: at the first edge with `reset` high, state → IDLE and all registered outputs → 0.
  - Outputs then read: `req_ready`=1, `busy`=0, `resp_*`=0, `mem_*`=0.
- Reset mid-operation aborts the access. No strobe is asserted in any cycle where `reset` is high.
- A pending sub-word store whose WRITE cycle has not yet occurred never writes.
- Latency from the accept edge E0 to the `resp_valid` cycle:
  - fault: 1 cycle (DONE after E0);
  - load: 2 cycles (READ, then DONE);
  - word store: 2 cycles (WRITE, then DONE);
  - sub-word store: 3 cycles (READ, WRITE, DONE).
- `resp_valid` is high for exactly one cycle. The next accept can occur at the edge ending DONE+1, i.e. once back in IDLE.
- `mem_addr` is stable for the whole READ and WRITE cycles. The read-modify-write reads and writes the same index.

## Test plan
- Preload word 3 = 0x8899AABB. lb at 0x0D → `mem_re` for 1 cycle with `mem_addr`=3. `resp_valid` 2 cycles after accept with `resp_rdata`=0xFFFFFFAA, `resp_fault`=0. lbu at 0x0D → 0x000000AA.
- sh `req_wdata`=0x00001234 at 0x0E, word 3 = 0x8899AABB → READ, then WRITE with `mem_wdata`=0x1234AABB and `mem_we` for exactly 1 cycle. `resp_valid` 3 cycles after accept. A following lw at 0x0C returns 0x1234AABB.
- lw at 0x0E; sh at 0x0D; size=11 at 0x00 → `resp_fault`=1 one cycle after accept, `resp_rdata`=0, and `mem_re`/`mem_we` never asserted.
- sw 0xDEADBEEF at 0x80 (index 32) → fault, memory unchanged. sw 0xDEADBEEF at 0x7C → `mem_addr`=31, `mem_wdata`=0xDEADBEEF; lw at 0x7C returns it.
- sb 0x55 at 0x0C. Assert `reset` in the READ cycle → `mem_we` never rises, `busy`=0 and `req_ready`=1 after that edge, word 3 unchanged.
- `req_valid` held high for back-to-back lw at 0x00 then 0x04 → second accept only after DONE. `busy` high exactly during READ/DONE. Two `resp_valid` pulses, no lost request.
